branch_resolver: RTL

- Pipeline-side partner of the 2-bit saturating branch predictor.
- Accepts branch lookups from fetch and issues `request` pulses to the predictor.
- Holds returned predictions in an in-order in-flight queue and matches them against resolved outcomes from execute.
- Drives `result`/`taken` training pulses back to the predictor, flags mispredicts (flushing younger entries) and keeps saturating branch/mispredict statistics.

---
 rtl/br_pkg.sv | 26 ++
 rtl/br_inflight_q.sv | 68 ++++++
 rtl/branch_resolver.sv | 95 +++++++++
 3 files changed

// File: rtl/br_pkg.sv
// br_pkg: shared defaults, update-record type and saturating increment for branch_resolver.
// Revision: 1.0
`default_nettype none

package br_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // Training pulse record presented to the predictor one cycle after a resolve.
  typedef struct packed {
    logic result;
    logic taken;
    logic mispredict;
  } upd_t;

  // Increment held in 32 bits; stops at 2^w-1 so callers of width w never wrap.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= maxv) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/br_inflight_q.sv
// br_inflight_q: in-order queue of 1-bit predictions with per-entry written flags.
// Revision: 1.0
`default_nettype none

module br_inflight_q
  import br_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic          wr_data,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] tail,
  output logic [AW:0]   count,
  output logic          head_valid,
  output logic          head_pred
);

  logic [AW-1:0]    head;
  logic [DEPTH-1:0] written;
  logic [DEPTH-1:0] data;

  assign head_valid = (count != '0) && written[head];
  assign head_pred  = data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      written <= '0;
    end else if (flush) begin
      // Flush always accompanies the pop of the mispredicted entry: drop it and everything younger.
      head    <= head + 1'b1;
      tail    <= head + 1'b1;
      count   <= '0;
      written <= '0;
    end else begin
      if (push) begin
        tail          <= tail + 1'b1;
        written[tail] <= 1'b0;
      end
      if (wr_en) begin
        written[wr_idx] <= 1'b1;
      end
      if (pop) begin
        head          <= head + 1'b1;
        written[head] <= 1'b0;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[wr_idx] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolver.sv
// branch_resolver: lookup/resolve handshake, predictor training pulses and mispredict statistics.
// Revision: 1.0
`default_nettype none

module branch_resolver
  import br_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  output logic             pred_req,
  input  logic             pred_in,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             res_ready,
  output logic             upd_result,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] tail;
  logic [AW-1:0] pend_idx;
  logic [AW:0]   count;
  logic          head_valid;
  logic          head_pred;
  logic          res_fire;
  logic          flush;
  upd_t          upd_q;

  assign br_ready   = (count != (AW+1)'(DEPTH));
  assign pred_req   = br_valid & br_ready;
  assign res_ready  = head_valid;
  assign res_fire   = res_valid & res_ready;
  assign flush      = res_fire & (head_pred != res_taken);
  assign pred_taken = pred_valid & pred_in;

  assign upd_result = upd_q.result;
  assign upd_taken  = upd_q.taken;
  assign mispredict = upd_q.mispredict;

  br_inflight_q #(
    .DEPTH (DEPTH)
  ) u_q (
    .clk        (clk),
    .rst        (rst),
    .push       (pred_req),
    .wr_en      (pred_valid),
    .wr_idx     (pend_idx),
    .wr_data    (pred_in),
    .pop        (res_fire),
    .flush      (flush),
    .tail       (tail),
    .count      (count),
    .head_valid (head_valid),
    .head_pred  (head_pred)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pend_idx   <= '0;
      upd_q      <= '0;
      br_count   <= '0;
      mp_count   <= '0;
    end else begin
      // A lookup accepted alongside a flushing resolve is younger, so its return is suppressed.
      pred_valid       <= pred_req & ~flush;
      upd_q.result     <= res_fire;
      upd_q.taken      <= res_fire & res_taken;
      upd_q.mispredict <= flush;
      if (pred_req) begin
        pend_idx <= tail;
      end
      if (res_fire) begin
        br_count <= CNT_W'(sat_inc(32'(br_count), CNT_W));
      end
      if (flush) begin
        mp_count <= CNT_W'(sat_inc(32'(mp_count), CNT_W));
      end
    end
  end

endmodule

`default_nettype wire
